// File: rtl/wb_unit_pkg.sv
// -----------------------------------------------------------------------------
// wb_unit_pkg
// Shared core defines for the writeback stage: data width, register address
// width, the zero register / zero word constants, and the source-select type
// used by the writeback arbiter.
// -----------------------------------------------------------------------------
package wb_unit_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG_ADDR = '0;
  localparam logic [XLEN-1:0]   ZERO_WORD     = '0;

  // Which source owns the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO buffering long-latency results ahead of writeback.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_push / i_wdata  enqueue request and data (ignored when full)
//   i_pop             dequeue request (ignored when empty)
//   o_rdata           current head entry (valid when !o_empty)
//   o_full / o_empty  occupancy flags, derived from the registered count
//   o_count           number of stored entries
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Head is read combinationally: the buffer is only a few entries deep and
  // the writeback flops downstream already provide the registered stage.
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_unit.sv
// -----------------------------------------------------------------------------
// wb_unit
// Writeback stage owning the single register-file write port. Merges the
// single-cycle ALU result with buffered long-latency results, forces a stall
// when a buffered result has lost arbitration too long, and tracks pending
// long-latency writes per GPR for decode's RAW hazard checks.
// Ports:
//   clk, rst                                  clock, sync active-high reset
//   alu_wr_en/_addr/_data                     ALU result (always accepted)
//   ll_valid/ll_ready/ll_addr/ll_data         long-latency result handshake
//   sb_set_en/sb_set_addr                     decode issued a long-latency op
//   sb_busy                                   pending-write bitmask (bit0 = 0)
//   wb_stall                                  upstream must idle the ALU port
//   rf_wr_en/_addr/_data                      registered register-file write
// -----------------------------------------------------------------------------
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = wb_unit_pkg::XLEN,
  parameter int REG_AW     = wb_unit_pkg::REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wr_en,
  input  logic [REG_AW-1:0]      alu_wr_addr,
  input  logic [XLEN-1:0]        alu_wr_data,
  input  logic                   ll_valid,
  output logic                   ll_ready,
  input  logic [REG_AW-1:0]      ll_addr,
  input  logic [XLEN-1:0]        ll_data,
  input  logic                   sb_set_en,
  input  logic [REG_AW-1:0]      sb_set_addr,
  output logic [2**REG_AW-1:0]   sb_busy,
  output logic                   wb_stall,
  output logic                   rf_wr_en,
  output logic [REG_AW-1:0]      rf_wr_addr,
  output logic [XLEN-1:0]        rf_wr_data
);

  localparam int NREG = 2**REG_AW;
  localparam int CW   = $clog2(STARVE_MAX + 1);
  localparam logic [REG_AW-1:0] ZADDR = REG_AW'(ZERO_REG_ADDR);

  // FIFO interface
  logic                       w_fifo_push;
  logic                       w_fifo_pop;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [$clog2(DEPTH):0]     w_fifo_count;
  logic [REG_AW+XLEN-1:0]     w_head;
  logic [REG_AW-1:0]          w_head_addr;
  logic [XLEN-1:0]            w_head_data;

  // Arbitration / state
  wb_sel_e                    w_sel;
  logic [CW-1:0]              r_starve_cnt;
  logic [CW-1:0]              w_starve_next;
  logic                       r_stall;
  logic [NREG-1:0]            r_busy;
  logic [NREG-1:0]            w_busy_next;
  logic                       r_rf_wr_en;
  logic [REG_AW-1:0]          r_rf_wr_addr;
  logic [XLEN-1:0]            r_rf_wr_data;

  assign ll_ready = !w_fifo_full;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_fifo_push = ll_valid && ll_ready && (ll_addr != ZADDR);
  assign w_fifo_pop  = (w_sel == SEL_FIFO);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (REG_AW + XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_wdata ({ll_addr, ll_data}),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign {w_head_addr, w_head_data} = w_head;

  // Arbiter. During a forced stall the ALU port is ignored outright, so a
  // misbehaving upstream cannot starve the buffer further.
  always_comb begin
    w_sel = SEL_NONE;
    if (r_stall) begin
      if (!w_fifo_empty) begin
        w_sel = SEL_FIFO;
      end
    end else if (alu_wr_en && (alu_wr_addr != ZADDR)) begin
      w_sel = SEL_ALU;
    end else if (!w_fifo_empty) begin
      w_sel = SEL_FIFO;
    end
  end

  // Starve counter only advances while the head exists and the ALU won.
  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_fifo_pop || (w_fifo_count == '0)) begin
      w_starve_next = '0;
    end else if ((w_sel == SEL_ALU) && (r_starve_cnt < CW'(STARVE_MAX))) begin
      w_starve_next = r_starve_cnt + 1'b1;
    end
  end

  // Scoreboard: a set is applied after the clear so a newly issued op to the
  // retiring register stays pending.
  always_comb begin
    w_busy_next = r_busy;
    if (w_fifo_pop) begin
      w_busy_next[w_head_addr] = 1'b0;
    end
    if (sb_set_en && (sb_set_addr != ZADDR)) begin
      w_busy_next[sb_set_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
      r_busy       <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_addr <= ZADDR;
      r_rf_wr_data <= XLEN'(ZERO_WORD);
    end else begin
      r_starve_cnt <= w_starve_next;
      // The pop during the stall cycle zeroes the counter, so this is a
      // single-cycle pulse.
      r_stall      <= (w_starve_next == CW'(STARVE_MAX));
      r_busy       <= w_busy_next;
      r_rf_wr_en   <= (w_sel != SEL_NONE);
      // Address/data hold their previous values on idle cycles.
      if (w_sel == SEL_ALU) begin
        r_rf_wr_addr <= alu_wr_addr;
        r_rf_wr_data <= alu_wr_data;
      end else if (w_sel == SEL_FIFO) begin
        r_rf_wr_addr <= w_head_addr;
        r_rf_wr_data <= w_head_data;
      end
    end
  end

  assign sb_busy    = r_busy;
  assign wb_stall   = r_stall;
  assign rf_wr_en   = r_rf_wr_en;
  assign rf_wr_addr = r_rf_wr_addr;
  assign rf_wr_data = r_rf_wr_data;

endmodule

// File: tb/tb_wb_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_unit
// Directed bench for wb_unit. Stimulus pushes each expected register-file
// write into a queue; a monitor pops and compares on every rf_wr_en cycle.
// Cycle-exact flags (stall, ready, busy bits) are checked inline.
// -----------------------------------------------------------------------------
module tb_wb_unit;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 alu_wr_en;
  logic [REG_AW-1:0]    alu_wr_addr;
  logic [XLEN-1:0]      alu_wr_data;
  logic                 ll_valid;
  logic                 ll_ready;
  logic [REG_AW-1:0]    ll_addr;
  logic [XLEN-1:0]      ll_data;
  logic                 sb_set_en;
  logic [REG_AW-1:0]    sb_set_addr;
  logic [2**REG_AW-1:0] sb_busy;
  logic                 wb_stall;
  logic                 rf_wr_en;
  logic [REG_AW-1:0]    rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  wb_unit #(
    .DEPTH      (2),
    .STARVE_MAX (4),
    .XLEN       (XLEN),
    .REG_AW     (REG_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_wr_en   (alu_wr_en),
    .alu_wr_addr (alu_wr_addr),
    .alu_wr_data (alu_wr_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_addr     (ll_addr),
    .ll_data     (ll_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_busy     (sb_busy),
    .wb_stall    (wb_stall),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every registered write must match the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (rf_wr_en === 1'b1) begin
      $display("rf write addr=%0d data=0x%08h", rf_wr_addr, rf_wr_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rf_unexpected: got addr=%0d data=0x%08h expected no write",
                 rf_wr_addr, rf_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_addr", 64'(rf_wr_addr), 64'(mon_e.addr));
        chk("rf_data", 64'(rf_wr_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_wr_en = 1'b0; alu_wr_addr = '0; alu_wr_data = '0;
    ll_valid = 1'b0;  ll_addr = '0;     ll_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;

    // Reset and idle
    repeat (3) tick();
    chk("rst_rf_en", 64'(rf_wr_en), 64'd0);
    chk("rst_rf_addr", 64'(rf_wr_addr), 64'd0);
    chk("rst_rf_data", 64'(rf_wr_data), 64'd0);
    chk("rst_ready", 64'(ll_ready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_rf_en", 64'(rf_wr_en), 64'd0);
      chk("idle_ready", 64'(ll_ready), 64'd1);
      chk("idle_busy", 64'(sb_busy), 64'd0);
      chk("idle_stall", 64'(wb_stall), 64'd0);
    end

    // ALU write, latency 1
    alu_wr_en = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'h1234;
    push_exp(5'd5, 32'h1234);
    tick();
    chk("alu_lat_en", 64'(rf_wr_en), 64'd1);
    chk("alu_lat_addr", 64'(rf_wr_addr), 64'd5);

    // ALU write to x0 is dropped; address/data hold
    alu_wr_addr = 5'd0; alu_wr_data = 32'hFFFF;
    tick();
    alu_wr_en = 1'b0;
    chk("alu_x0_en", 64'(rf_wr_en), 64'd0);
    chk("alu_x0_hold_addr", 64'(rf_wr_addr), 64'd5);
    chk("alu_x0_hold_data", 64'(rf_wr_data), 64'h1234);

    // Long-latency path with scoreboard clear
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set_en = 1'b0;
    chk("sb_set7", 64'(sb_busy[7]), 64'd1);
    ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'hDEADBEEF;
    push_exp(5'd7, 32'hDEADBEEF);
    tick();
    ll_valid = 1'b0;
    chk("ll_push_nowr", 64'(rf_wr_en), 64'd0);
    chk("ll_sb7_pending", 64'(sb_busy[7]), 64'd1);
    tick();
    chk("ll_wr_en", 64'(rf_wr_en), 64'd1);
    chk("ll_sb7_clear", 64'(sb_busy[7]), 64'd0);

    // Starvation: ALU busy except on the forced-pop cycles 5 and 10
    for (int c = 0; c < 12; c++) begin
      alu_wr_en   = (c < 10) && (c != 5);
      alu_wr_addr = 5'd10;
      alu_wr_data = 32'h100 + 32'(c);
      ll_valid    = (c < 2);
      ll_addr     = (c == 0) ? 5'd11 : 5'd12;
      ll_data     = (c == 0) ? 32'hAAAA0001 : 32'hBBBB0002;
      if (alu_wr_en) push_exp(5'd10, 32'h100 + 32'(c));
      if (c == 5)    push_exp(5'd11, 32'hAAAA0001);
      if (c == 10)   push_exp(5'd12, 32'hBBBB0002);
      tick();
      chk($sformatf("starve_stall_c%0d", c), 64'(wb_stall), 64'((c == 4) || (c == 9)));
      chk($sformatf("starve_ready_c%0d", c), 64'(ll_ready), 64'(!((c >= 1) && (c <= 4))));
    end
    alu_wr_en = 1'b0; ll_valid = 1'b0;

    // ll write to x0: accepted, never written
    ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'h5555;
    tick();
    ll_valid = 1'b0;
    chk("ll_x0_ready", 64'(ll_ready), 64'd1);
    tick();
    chk("ll_x0_nowr", 64'(rf_wr_en), 64'd0);

    // Same-edge set and FIFO retire of x3: set wins
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick();
    sb_set_en = 1'b0;
    ll_valid = 1'b1; ll_addr = 5'd3; ll_data = 32'h33;
    push_exp(5'd3, 32'h33);
    tick();
    ll_valid = 1'b0;
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick();
    sb_set_en = 1'b0;
    chk("same_edge_wr", 64'(rf_wr_en), 64'd1);
    chk("same_edge_busy3", 64'(sb_busy[3]), 64'd1);
    tick();
    chk("same_edge_busy3_hold", 64'(sb_busy[3]), 64'd1);

    // Reset mid-operation with two buffered entries and busy bits set
    sb_set_en = 1'b1; sb_set_addr = 5'd20;
    tick();
    sb_set_addr = 5'd21;
    tick();
    sb_set_en = 1'b0;
    chk("pre_rst_busy", 64'(sb_busy), 64'h0030_0008);
    alu_wr_en = 1'b1; alu_wr_addr = 5'd9; alu_wr_data = 32'h900;
    ll_valid = 1'b1; ll_addr = 5'd20; ll_data = 32'h2020;
    push_exp(5'd9, 32'h900);
    tick();
    alu_wr_data = 32'h901; ll_addr = 5'd21; ll_data = 32'h2121;
    push_exp(5'd9, 32'h901);
    tick();
    chk("pre_rst_full", 64'(ll_ready), 64'd0);
    rst = 1'b1; alu_wr_en = 1'b0; ll_valid = 1'b0;
    tick();
    chk("midrst_rf_en", 64'(rf_wr_en), 64'd0);
    chk("midrst_ready", 64'(ll_ready), 64'd1);
    chk("midrst_busy", 64'(sb_busy), 64'd0);
    chk("midrst_stall", 64'(wb_stall), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_nowr", 64'(rf_wr_en), 64'd0);
    end

    tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
